// File: rtl/oflow_score_calc_multi_if.sv
// ---------------------------------------------------------------------------
// oflow_score_calc_multi_if
//   Previous-object feature stream into oflow_score_calc_multi.
//   One beat carries NUM_SM feature words (lane k = feat[k*FEAT_W +: FEAT_W]).
//
//   valid     source -> sink   beat valid
//   ready     sink   -> source sink accepts the beat (valid & ready)
//   feat      source -> sink   NUM_SM packed feature words
//   lane_vld  source -> sink   per-lane valid within the beat
//   last      source -> sink   final beat of the run
//
//   master: feature buffer side, slave: score calculator side.
// ---------------------------------------------------------------------------
interface oflow_score_calc_multi_if #(
  parameter int unsigned NUM_SM = 2,
  parameter int unsigned FEAT_W = 156
);
  logic                       valid;
  logic                       ready;
  logic [NUM_SM*FEAT_W-1:0]   feat;
  logic [NUM_SM-1:0]          lane_vld;
  logic                       last;

  modport master (output valid, feat, lane_vld, last, input ready);
  modport slave  (input valid, feat, lane_vld, last, output ready);
endinterface

// File: rtl/oflow_score_calc_multi.sv
// ---------------------------------------------------------------------------
// oflow_score_calc_multi
//   Holds one current object's features and weights, streams previous-frame
//   objects through NUM_SM parallel similarity lanes, and keeps the lowest
//   score of the run together with its id. A one-cycle done pulse marks the
//   results valid; results hold until the next start.
//
//   Optional feature macro: SCORE_CALC_THRESH_EN
//     adds thresh_score (in) and no_match (out). When the final best score is
//     above thresh_score, no_match is raised and best_id is forced to all ones.
//
// Ports
//   clk, reset_N          clock, asynchronous active-low reset
//   start                 begin a run (ignored unless idle)
//   *_cur                 current object features, sampled one cycle after start
//   *_weight              metric weights, sampled with the features
//   prev                  previous-object beat stream (slave modport)
//   busy                  run in progress (capture through done)
//   done                  one-cycle pulse, results valid
//   best_score, best_id   lowest score of the run and its id
//   num_scored            number of valid lanes scored this run
//   err_ovf               run hit the beat limit without last
//
// oflow_similarity_metric (this file) is the scoring lane: a LAT-deep pipeline
// returning score = feat[SCORE_W-1:0] and id = feat[FEAT_W-1 -: ID_W]. The
// current features and weights are routed to it so a full metric can drop in
// behind the same ports.
// ---------------------------------------------------------------------------
module oflow_similarity_metric #(
  parameter int unsigned LAT     = 2,
  parameter int unsigned FEAT_W  = 156,
  parameter int unsigned SCORE_W = 32,
  parameter int unsigned ID_W    = 12,
  parameter int unsigned CUR_W   = 144,
  parameter int unsigned WGT_W   = 192
) (
  input  logic               clk,
  input  logic [CUR_W-1:0]   cur_feat,
  input  logic [WGT_W-1:0]   weights,
  input  logic [FEAT_W-1:0]  feat,
  output logic [SCORE_W-1:0] score,
  output logic [ID_W-1:0]    id
);
  logic [LAT-1:0][SCORE_W-1:0] score_pipe;
  logic [LAT-1:0][ID_W-1:0]    id_pipe;
  logic                        unused_inputs;

  assign unused_inputs = ^{cur_feat, weights, feat[FEAT_W-ID_W-1:SCORE_W]};

  if (LAT == 1) begin : g_one
    always_ff @(posedge clk) begin
      score_pipe <= feat[SCORE_W-1:0];
      id_pipe    <= feat[FEAT_W-1 -: ID_W];
    end
  end else begin : g_multi
    always_ff @(posedge clk) begin
      score_pipe <= {score_pipe[LAT-2:0], feat[SCORE_W-1:0]};
      id_pipe    <= {id_pipe[LAT-2:0], feat[FEAT_W-1 -: ID_W]};
    end
  end

  assign score = score_pipe[LAT-1];
  assign id    = id_pipe[LAT-1];
endmodule

module oflow_score_calc_multi #(
  parameter  int unsigned NUM_SM   = 2,
  parameter  int unsigned MAX_PREV = 64,
  parameter  int unsigned SM_LAT   = 2,
  parameter  int unsigned FEAT_W   = 156,
  parameter  int unsigned SCORE_W  = 32,
  parameter  int unsigned ID_W     = 12,
  localparam int unsigned NS_W     = $clog2(MAX_PREV + 1)
) (
  input  logic                clk,
  input  logic                reset_N,
  input  logic                start,
  input  logic [21:0]         cm_concate_cur,
  input  logic [43:0]         position_concate_cur,
  input  logic [10:0]         width_cur,
  input  logic [10:0]         height_cur,
  input  logic [23:0]         color1_cur,
  input  logic [23:0]         color2_cur,
  input  logic [7:0]          d_history_cur,
  input  logic [31:0]         iou_weight,
  input  logic [31:0]         w_weight,
  input  logic [31:0]         h_weight,
  input  logic [31:0]         color1_weight,
  input  logic [31:0]         color2_weight,
  input  logic [31:0]         dhistory_weight,
  oflow_score_calc_multi_if.slave prev,
  output logic                busy,
  output logic                done,
  output logic [SCORE_W-1:0]  best_score,
  output logic [ID_W-1:0]     best_id,
  output logic [NS_W-1:0]     num_scored,
  output logic                err_ovf
`ifdef SCORE_CALC_THRESH_EN
  ,
  input  logic [SCORE_W-1:0]  thresh_score,
  output logic                no_match
`endif
);
  localparam int unsigned LIMIT = (MAX_PREV + NUM_SM - 1) / NUM_SM;
  localparam int unsigned BW    = $clog2(LIMIT + 1);
  localparam int unsigned DW    = $clog2(SM_LAT + 1);
  localparam int unsigned LW    = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;
  localparam int unsigned CW    = $clog2(NUM_SM + 1);
  localparam int unsigned CUR_W = 144;
  localparam int unsigned WGT_W = 192;

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t                          state;
  logic                            ready_q;
  logic                            accept;
  logic [BW-1:0]                   beats;
  logic [DW-1:0]                   drain_cnt;
  logic [CUR_W-1:0]                cur_q;
  logic [WGT_W-1:0]                wgt_q;

  logic [SM_LAT-1:0][NUM_SM-1:0]   vld_pipe;
  logic [NUM_SM-1:0]               lane_ok;
  logic [NUM_SM-1:0][SCORE_W-1:0]  lane_score;
  logic [NUM_SM-1:0][ID_W-1:0]     lane_id;

  logic                            beat_any;
  logic [SCORE_W-1:0]              beat_min;
  logic [ID_W-1:0]                 beat_id;
  logic [CW-1:0]                   beat_cnt;

  logic                            cmp_any;
  logic [SCORE_W-1:0]              cmp_min;
  logic [ID_W-1:0]                 cmp_id;
  logic [CW-1:0]                   cmp_cnt;
  logic                            cmp_wins;

  assign prev.ready = ready_q;
  assign accept     = prev.valid & ready_q;

  // Per-lane valid travels alongside the lane pipeline; only accepted beats
  // inject valid lanes, so idle cycles flush through as invalid.
  if (SM_LAT == 1) begin : g_vld_one
    always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) vld_pipe <= '0;
      else          vld_pipe <= prev.lane_vld & {NUM_SM{accept}};
    end
  end else begin : g_vld_multi
    always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) vld_pipe <= '0;
      else          vld_pipe <= {vld_pipe[SM_LAT-2:0], prev.lane_vld & {NUM_SM{accept}}};
    end
  end

  assign lane_ok = vld_pipe[SM_LAT-1];

  for (genvar k = 0; k < NUM_SM; k++) begin : g_lane
    oflow_similarity_metric #(
      .LAT     (SM_LAT),
      .FEAT_W  (FEAT_W),
      .SCORE_W (SCORE_W),
      .ID_W    (ID_W),
      .CUR_W   (CUR_W),
      .WGT_W   (WGT_W)
    ) u_sm (
      .clk      (clk),
      .cur_feat (cur_q),
      .weights  (wgt_q),
      .feat     (prev.feat[k*FEAT_W +: FEAT_W]),
      .score    (lane_score[k]),
      .id       (lane_id[k])
    );
  end

  // Beat minimum: scanning upward with strict < keeps the lower lane on ties.
  always_comb begin
    beat_any = 1'b0;
    beat_min = '1;
    beat_id  = '1;
    beat_cnt = '0;
    for (int unsigned k = 0; k < NUM_SM; k++) begin
      if (lane_ok[k[LW-1:0]]) begin
        beat_cnt = beat_cnt + CW'(1);
        if (!beat_any || (lane_score[k[LW-1:0]] < beat_min)) begin
          beat_min = lane_score[k[LW-1:0]];
          beat_id  = lane_id[k[LW-1:0]];
        end
        beat_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      cmp_any <= 1'b0;
      cmp_min <= '1;
      cmp_id  <= '1;
      cmp_cnt <= '0;
    end else begin
      cmp_any <= beat_any;
      cmp_min <= beat_min;
      cmp_id  <= beat_id;
      cmp_cnt <= beat_cnt;
    end
  end

  // Strict < against the running best: earlier beats win ties, and an
  // all-ones score can never displace the all-ones initial value.
  assign cmp_wins = cmp_any && (cmp_min < best_score);

`ifdef SCORE_CALC_THRESH_EN
  logic [SCORE_W-1:0] final_score;
  // The last compare update lands on the same edge that enters DONE, so the
  // threshold looks at the value best_score is about to take.
  assign final_score = cmp_wins ? cmp_min : best_score;
`endif

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state      <= S_IDLE;
      ready_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      best_score <= '1;
      best_id    <= '1;
      num_scored <= '0;
      err_ovf    <= 1'b0;
      beats      <= '0;
      drain_cnt  <= '0;
      cur_q      <= '0;
      wgt_q      <= '0;
`ifdef SCORE_CALC_THRESH_EN
      no_match   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      if (cmp_any) num_scored <= num_scored + NS_W'(cmp_cnt);
      if (cmp_wins) begin
        best_score <= cmp_min;
        best_id    <= cmp_id;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_CAPTURE;
            busy       <= 1'b1;
            best_score <= '1;
            best_id    <= '1;
            num_scored <= '0;
            err_ovf    <= 1'b0;
`ifdef SCORE_CALC_THRESH_EN
            no_match   <= 1'b0;
`endif
          end
        end
        S_CAPTURE: begin
          cur_q   <= {cm_concate_cur, position_concate_cur, width_cur, height_cur,
                      color1_cur, color2_cur, d_history_cur};
          wgt_q   <= {iou_weight, w_weight, h_weight, color1_weight,
                      color2_weight, dhistory_weight};
          beats   <= '0;
          ready_q <= 1'b1;
          state   <= S_STREAM;
        end
        S_STREAM: begin
          if (accept) begin
            beats <= beats + BW'(1);
            if (prev.last || (beats == BW'(LIMIT - 1))) begin
              ready_q   <= 1'b0;
              drain_cnt <= '0;
              err_ovf   <= ~prev.last;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(SM_LAT)) begin
            state <= S_DONE;
            done  <= 1'b1;
`ifdef SCORE_CALC_THRESH_EN
            if (final_score > thresh_score) begin
              no_match <= 1'b1;
              best_id  <= '1;
            end
`endif
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
